// File: rtl/alu_pkg.sv
// alu_pkg: opcode and arbiter state encodings shared by the ALU arbiter files
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        SEND_X,
        SEND_Y,
        WAIT,
        WAIT2,
        RESP
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning upward from ptr+1 with wrap
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         pick,
    output logic                 any
);
    localparam int PW = $clog2(N);

    logic [PW-1:0] idx;

    // first requester found after the last winner gets the one-hot pick
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int i = 1; i <= N; i++) begin
            idx = PW'((int'(ptr) + i) % N);
            if (req[idx] && pick == '0) pick[idx] = 1'b1;
        end
    end

    assign any = |req;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one serial-operand ALU; ALU_ARB_TIMEOUT_EN adds a per-word result timeout
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W       = 8,
    parameter int N       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [2*N-1:0]       req_op,
    input  logic [W*N-1:0]       req_x,
    input  logic [W*N-1:0]       req_y,
    output logic [N-1:0]         gnt,
    output logic                 rsp_valid,
    output logic [$clog2(N)-1:0] rsp_id,
    output logic [W-1:0]         rsp_hi,
    output logic [W-1:0]         rsp_lo,
    output logic                 rsp_err,
    output logic                 alu_valid,
    output logic [1:0]           alu_op,
    output logic [W-1:0]         alu_in,
    input  logic [W-1:0]         alu_o,
    input  logic                 alu_ready
);
    localparam int PW = $clog2(N);

    if (N < 2 || N > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("alu_arbiter: N must be 2..8 and TIMEOUT at least 1");
    end

    state_e        state, state_nx;
    logic [PW-1:0] ptr, id_r, k;
    op_e           op_r;
    logic [W-1:0]  y_r, hi_r;
    logic [N-1:0]  pick;
    logic          any, grant, waiting, ready_acc, expired, busy_nx;
    logic [1:0]    sel_op;
    logic [W-1:0]  sel_x, sel_y;

    rr_arbiter #(.N(N)) u_rr (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .any  (any)
    );

    // binary index of the one-hot pick, used to select the winner's operands
    always_comb begin
        k = '0;
        for (int i = 0; i < N; i++) if (pick[i]) k = PW'(i);
    end

    assign sel_op    = req_op[2*k +: 2];
    assign sel_x     = req_x[W*k +: W];
    assign sel_y     = req_y[W*k +: W];
    assign grant     = state == IDLE && any;
    assign gnt       = (grant && rst) ? pick : '0;
    assign waiting   = state == WAIT || state == WAIT2;
    assign ready_acc = waiting && alu_ready;
    assign busy_nx   = state_nx == SEND_X || state_nx == SEND_Y || state_nx == WAIT || state_nx == WAIT2;

`ifdef ALU_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // cycles spent waiting for the current result word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= '0;
        else cnt <= (state == SEND_Y || ready_acc) ? '0 : waiting ? cnt + CW'(1) : cnt;
    end

    assign expired = waiting && cnt == CW'(TIMEOUT - 1);
`else
    assign expired = 1'b0;
`endif

    // next-state decode for the grant / send / wait / respond sequence
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any) state_nx = (op_e'(sel_op) == OP_RSV) ? RESP : SEND_X;
            SEND_X:  state_nx = SEND_Y;
            SEND_Y:  state_nx = WAIT;
            WAIT:    if (alu_ready) state_nx = (op_r == OP_MUL) ? WAIT2 : RESP;
                     else if (expired) state_nx = RESP;
            WAIT2:   if (alu_ready || expired) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state, captured request and registered outputs, all derived from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= PW'(N - 1);
            id_r      <= '0;
            op_r      <= OP_ADD;
            y_r       <= '0;
            hi_r      <= '0;
            alu_valid <= 1'b0;
            alu_op    <= '0;
            alu_in    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_hi    <= '0;
            rsp_lo    <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant) begin
                ptr  <= k;
                id_r <= k;
                op_r <= op_e'(sel_op);
                y_r  <= sel_y;
                hi_r <= '0;
            end
            if (state == WAIT && alu_ready && op_r == OP_MUL) hi_r <= alu_o;
            alu_valid <= state_nx == SEND_X;
            alu_op    <= busy_nx ? (state == IDLE ? sel_op : op_r) : 2'b00;
            alu_in    <= state_nx == SEND_X ? sel_x : state_nx == SEND_Y ? y_r : '0;
            rsp_valid <= state_nx == RESP;
            rsp_id    <= state_nx == RESP ? (state == IDLE ? k : id_r) : '0;
            rsp_hi    <= (state_nx == RESP && state == WAIT2) ? hi_r : '0;
            rsp_lo    <= (state_nx == RESP && ready_acc) ? alu_o : '0;
            rsp_err   <= state_nx == RESP && !ready_acc;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vector bench for alu_arbiter; honours ALU_ARB_TIMEOUT_EN
module tb_alu_arbiter;
    localparam int W = 8;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   req = '0;
    logic [2*N-1:0] req_op = '0;
    logic [W*N-1:0] req_x = '0;
    logic [W*N-1:0] req_y = '0;
    logic [N-1:0]   gnt;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_hi, rsp_lo;
    logic           rsp_err;
    logic           alu_valid;
    logic [1:0]     alu_op;
    logic [W-1:0]   alu_in;
    logic [W-1:0]   alu_o = '0;
    logic           alu_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.W(W), .N(N), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_op    (req_op),
        .req_x     (req_x),
        .req_y     (req_y),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_hi    (rsp_hi),
        .rsp_lo    (rsp_lo),
        .rsp_err   (rsp_err),
        .alu_valid (alu_valid),
        .alu_op    (alu_op),
        .alu_in    (alu_in),
        .alu_o     (alu_o),
        .alu_ready (alu_ready)
    );

    typedef struct {
        int         id;
        logic [1:0] op;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] hi;
        logic [7:0] lo;
        logic       err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setup(input int id, input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
        req_op[2*id +: 2] = op;
        req_x[W*id +: W]  = x;
        req_y[W*id +: W]  = y;
        req[id]           = 1'b1;
        #1;
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (gnt != '0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("gnt_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        alu_ready = 1'b0;
        alu_o = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        setup(v.id, v.op, v.x, v.y);
        wait_gnt(ok);
        if (!ok) return;
        chk("vec_gnt", 32'(gnt), 32'(1 << v.id));
        @(negedge clk);
        req[v.id] = 1'b0;
        if (v.op == 2'b11) begin
            chk("rsv_alu_valid", 32'(alu_valid), 32'd0);
        end else begin
            chk("send_x_valid", 32'(alu_valid), 32'd1);
            chk("send_x_in", 32'(alu_in), 32'(v.x));
            chk("send_x_op", 32'(alu_op), 32'(v.op));
            @(negedge clk);
            chk("send_y_valid", 32'(alu_valid), 32'd0);
            chk("send_y_in", 32'(alu_in), 32'(v.y));
            chk("send_y_op", 32'(alu_op), 32'(v.op));
            @(negedge clk);
            alu_ready = 1'b1;
            alu_o = (v.op == 2'b10) ? v.hi : v.lo;
            if (v.op == 2'b10) begin
                @(negedge clk);
                alu_ready = 1'b0;
                alu_o = '0;
                chk("mul_mid_rsp", 32'(rsp_valid), 32'd0);
                @(negedge clk);
                alu_ready = 1'b1;
                alu_o = v.lo;
            end
            @(negedge clk);
            alu_ready = 1'b0;
            alu_o = '0;
        end
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_id", 32'(rsp_id), 32'(v.id));
        chk("rsp_hi", 32'(rsp_hi), 32'(v.hi));
        chk("rsp_lo", 32'(rsp_lo), 32'(v.lo));
        chk("rsp_err", 32'(rsp_err), 32'(v.err));
        @(negedge clk);
        chk("rsp_strobe_end", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int busy;
        int seen;
        vecs[0] = '{1, 2'b00, 8'd20,  8'd7,  8'h00, 8'd27,  1'b0};
        vecs[1] = '{0, 2'b10, 8'hFD,  8'd5,  8'hFF, 8'hF1,  1'b0};
        vecs[2] = '{2, 2'b11, 8'h12,  8'h34, 8'h00, 8'h00,  1'b1};
        vecs[3] = '{3, 2'b01, 8'd10,  8'd20, 8'h00, 8'hF6,  1'b0};
        vecs[4] = '{0, 2'b00, 8'hFF,  8'h02, 8'h00, 8'h01,  1'b0};
        vecs[5] = '{1, 2'b10, 8'h10,  8'h10, 8'h01, 8'h00,  1'b0};
        vecs[6] = '{3, 2'b10, 8'h7F,  8'h7F, 8'h3F, 8'h01,  1'b0};
        vecs[7] = '{2, 2'b01, 8'h05,  8'h05, 8'h00, 8'h00,  1'b0};

        @(negedge clk);
        chk("reset_alu_valid", 32'(alu_valid), 32'd0);
        chk("reset_alu_in", 32'(alu_in), 32'd0);
        chk("reset_alu_op", 32'(alu_op), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_gnt", 32'(gnt), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        setup(0, 2'b10, 8'h03, 8'h04);
        wait_gnt(ok);
        chk("mr_gnt", 32'(gnt), 32'd1);
        @(negedge clk);
        req[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        alu_ready = 1'b1;
        alu_o = 8'h00;
        @(negedge clk);
        alu_ready = 1'b0;
        chk("mr_op_before_reset", 32'(alu_op), 32'd2);
        rst = 1'b0;
        req = 4'b1001;
        #1;
        chk("mr_alu_op", 32'(alu_op), 32'd0);
        chk("mr_alu_in", 32'(alu_in), 32'd0);
        chk("mr_alu_valid", 32'(alu_valid), 32'd0);
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mr_gnt_in_reset", 32'(gnt), 32'd0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            seen |= int'(rsp_valid);
        end
        chk("mr_no_rsp", 32'(seen), 32'd0);
        rst = 1'b1;
        #1;
        chk("mr_first_gnt", 32'(gnt), 32'd1);
        req = '0;
        @(negedge clk);

        for (int i = 0; i < N; i++) begin
            req_op[2*i +: 2] = 2'b00;
            req_x[W*i +: W] = 8'(i);
            req_y[W*i +: W] = 8'd1;
        end
        req = '1;
        #1;
        wait_gnt(ok);
        for (int j = 0; j < 8; j++) begin
            chk("rr_gnt", 32'(gnt), 32'(1 << (j % 4)));
            busy = 0;
            @(negedge clk);
            busy |= int'(gnt);
            @(negedge clk);
            busy |= int'(gnt);
            @(negedge clk);
            busy |= int'(gnt);
            alu_ready = 1'b1;
            alu_o = 8'(j + 1);
            @(negedge clk);
            busy |= int'(gnt);
            alu_ready = 1'b0;
            chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rr_rsp_id", 32'(rsp_id), 32'(j % 4));
            chk("rr_rsp_lo", 32'(rsp_lo), 32'(j + 1));
            chk("rr_busy_gnt", 32'(busy), 32'd0);
            @(negedge clk);
        end
        req = '0;
        #1;

        setup(1, 2'b00, 8'd1, 8'd2);
        wait_gnt(ok);
        @(negedge clk);
        req[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
`ifdef ALU_ARB_TIMEOUT_EN
        seen = 0;
        for (int c = 0; c < 16; c++) begin
            seen |= int'(rsp_valid);
            @(negedge clk);
        end
        chk("to_early_rsp", 32'(seen), 32'd0);
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        chk("to_rsp_lo", 32'(rsp_lo), 32'd0);
        chk("to_rsp_id", 32'(rsp_id), 32'd1);
        @(negedge clk);
`else
        seen = 0;
        repeat (100) begin
            seen |= int'(rsp_valid);
            @(negedge clk);
        end
        chk("nto_no_rsp", 32'(seen), 32'd0);
        do_reset();
`endif
        chk("end_idle_rsp", 32'(rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one serial-operand ALU among N requesters. Grants requests round-robin and drives the ALU's valid/operand sequence. Collects the one- or two-word result and returns it to the granted requester with an ID tag. Sits between the requesting engines and the ALU instance; it is the only driver of the ALU's `valid`, `in` and `op_codes`.

## Interface
- `W`, 8: operand/result word width.
- `N`, 4: number of requesters, 2..8.
- `TIMEOUT`, 64: maximum cycles waited per ALU result word. Used only with `ALU_ARB_TIMEOUT_EN`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req`  in  N  level request per requester; held until its `gnt` bit pulses.
- `req_op`  in  2*N  requester i opcode at `[2i +: 2]`: 00 add, 01 sub, 10 mul, 11 reserved.
- `req_x`, `req_y`  in  W*N  requester i operands at `[W*i +: W]`.
- `gnt`  out  N  one-hot, one-cycle pulse; operands are sampled in that cycle.
- `rsp_valid`  out  1  one-cycle response strobe.
- `rsp_id`  out  $clog2(N)  requester index of the response.
- `rsp_hi`, `rsp_lo`  out  W  result; `rsp_hi` is nonzero only for mul.
- `rsp_err`  out  1  reserved opcode or timeout.
- `alu_valid`  out  1  start strobe to the ALU.
- `alu_op`  out  2  ALU op_codes.
- `alu_in`  out  W  ALU operand bus.
- `alu_o`  in  W  ALU result bus.
- `alu_ready`  in  1  ALU result strobe.

## Operation
- FSM states: IDLE, SEND_X, SEND_Y, WAIT, WAIT2, RESP.
- IDLE:
  - If any `req` is set, pick the first set bit scanning from `ptr+1` upward with wrap.
  - Pulse `gnt[k]`, capture op/x/y/k, and set `ptr<=k`.
  - If op=11, go to RESP with `rsp_err=1` and zero result; the ALU is untouched.
  - Otherwise go to SEND_X.
- SEND_X: `alu_valid=1`, `alu_in=x`, `alu_op=op`; go to SEND_Y.
- SEND_Y: `alu_valid=0`, `alu_in=y`, `alu_op` held; go to WAIT.
- WAIT:
  - On `alu_ready`, for add/sub capture `alu_o` into lo and go to RESP.
  - For mul, capture `alu_o` into hi and go to WAIT2.
- WAIT2: on `alu_ready`, capture `alu_o` into lo; go to RESP.
- RESP: `rsp_valid=1` with the captured id/hi/lo/err; go to IDLE. No grant is issued in RESP.
- `alu_op` is held from SEND_X until leaving WAIT/WAIT2. `alu_in` is 0 outside SEND_X/SEND_Y.
- `alu_ready` is ignored outside WAIT/WAIT2.
- Add/sub results are W bits, wrapping; carry is discarded by the ALU. Mul results are signed 2W bits, split hi:lo.
- `req` dropping before grant withdraws the request; `req` changing after grant has no effect.
- Reset (any time, including mid-operation):
  - State returns to IDLE and `ptr` to N-1, so requester 0 is scanned first.
  - All outputs go to 0.
  - An operation in flight is lost, with no response.

## Timing
- Grant at cycle T, `alu_valid` at T+1, y on `alu_in` at T+2.
- `rsp_valid` comes one cycle after the capturing `alu_ready` edge.
- Reserved op: `rsp_valid` at T+1.
- Back-to-back: the earliest next grant is the cycle after RESP. Minimum spacing is 5 cycles for add/sub with immediate ready.
- `alu_ready` in the first WAIT cycle (T+3) is accepted.
- All outputs are registered except `gnt`, which is decoded from IDLE plus the arbiter pick.

## Configuration
- `ALU_ARB_TIMEOUT_EN` defined:
  - A cycle counter clears on entry to WAIT and on each accepted `alu_ready`, and increments in WAIT/WAIT2.
  - When it reaches `TIMEOUT` without ready, go to RESP with `rsp_err=1`. Any already captured hi word is kept; lo is 0.
- Not defined: no counter; WAIT/WAIT2 wait indefinitely and `rsp_err` is set only for op=11.

## Structure
- `alu_pkg`: opcode enum (`OP_ADD`, `OP_SUB`, `OP_MUL`, `OP_RSV`) and arbiter state enum.
- One sub-module, `rr_arbiter` (parameter N): inputs `req` and `ptr`; output one-hot `pick` plus `any`. Purely combinational.

## Test plan
- Single add: `req[1]`, x=8'd20, y=8'd7, op=00; ALU readies at T+3 with 8'd27. Expect `gnt[1]` at T, `alu_valid` at T+1 only, `rsp_valid` at T+4 with id=1, lo=27, hi=0, err=0.
- Mul: `req[0]`, op=10, x=8'hFD (-3), y=8'd5; ALU returns 8'hFF then 8'hF1. Expect the response with hi=FF, lo=F1 after the second ready.
- Round-robin: all `req` held for 8 operations. Expect grant order 0,1,2,3,0,1,2,3 with no grant during busy states.
- Reserved op: `req[2]` with op=11. Expect `gnt[2]` at T, `rsp_valid` at T+1 with err=1, and `alu_valid` never asserted.
- Reset mid-mul: assert `rst`=0 during WAIT2. Expect all outputs 0 immediately and no `rsp_valid`. After release, `req[3]` and `req[0]` are both set; expect `gnt[0]` first.
- With `ALU_ARB_TIMEOUT_EN` and TIMEOUT=16: ALU never readies. Expect `rsp_valid` with err=1, lo=0 exactly 16 cycles after WAIT entry. Without the macro, expect no response in 100 cycles.
